core_lsu: RTL and testbench
===========================

CORE_LSU -- requirements
Module: core_lsu

Interface
REQ-001 SHALL have parameter SPLIT_EN, default 1; when 1, misaligned accesses are split into byte accesses; when 0, misaligned accesses are rejected with rsp_err.
REQ-002 SHALL have port sclk, input, 1 bit: clock; all state updates on rising edge.
REQ-003 SHALL have port rstn, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port req_valid, input, 1 bit: access request from execute stage.
REQ-005 SHALL have port req_ready, output, 1 bit: request accepted when req_valid && req_ready.
REQ-006 SHALL have port req_wr, input, 1 bit: 1 = store, 0 = load.
REQ-007 SHALL have port req_op, input, 3 bits: funct3 encoding (LB 000, LH 001, LW 010, LBU 100, LHU 101; SB 000, SH 001, SW 010).
REQ-008 SHALL have ports req_addr (input, 32 bits: byte address) and req_wdata (input, 32 bits: store data, right-aligned).
REQ-009 SHALL have ports rsp_valid (output, 1 bit: one-cycle completion pulse), rsp_rdata (output, 32 bits: load result, extended) and rsp_err (output, 1 bit: misaligned or illegal op, qualified by rsp_valid).
REQ-010 SHALL have ports mem_wr and mem_rd (outputs, 1 bit each), mem_op (output, 3 bits), mem_addr (output, 32 bits), mem_wdata (output, 32 bits, right-aligned) and mem_rdata (input, 32 bits, already lane-selected and extended by the data memory, valid the cycle after mem_rd).

Function
REQ-011 SHALL implement states IDLE and SPLIT; req_ready = 1 in IDLE and 0 in SPLIT.
REQ-012 SHALL classify an access as misaligned when the op is LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0; byte ops are never misaligned.
REQ-013 SHALL treat load ops 011/110/111 and store ops other than 000/001/010 as illegal: no memory access, and rsp_valid=1, rsp_err=1, rsp_rdata=0 on the cycle after accept.
REQ-014 SHALL drive the memory command combinationally in the accept cycle N for an aligned access: mem_rd or mem_wr=1, mem_op=req_op, mem_addr=req_addr, mem_wdata=req_wdata.
REQ-015 SHALL, for an aligned access, assert rsp_valid in N+1 with rsp_err=0; rsp_rdata=mem_rdata for a load and 0 for a store; the state remains IDLE, so back-to-back accepts every cycle are supported.
REQ-016 SHALL, with SPLIT_EN=1, decompose a misaligned access into n byte accesses (n=2 for halfword, n=4 for word); byte k is issued in cycle N+k at address req_addr+k (32-bit wrap-around), with byte 0 issued in the accept cycle.
REQ-017 SHALL issue split loads as mem_op=LBU (100) and split stores as mem_op=SB (000), with mem_wdata={24'd0, wdata byte k}, little-endian.
REQ-018 SHALL register base address, op, wr, wdata and byte counter at accept, enter SPLIT in N+1, and return to IDLE after the issue in N+n-1.
REQ-019 SHALL capture the returned byte k-1 (mem_rdata[7:0]) into assembly bits [8(k-1)+7:8(k-1)] at each cycle of a split load.
REQ-020 SHALL assert rsp_valid in N+n; rsp_rdata = assembled bytes merged combinationally with the final byte from mem_rdata, sign-extended for LH and zero-extended for LHU, LW unmodified; 0 for stores.
REQ-021 SHALL raise req_ready again in N+n, allowing a new accept in the same cycle as the split response.
REQ-022 SHALL, with SPLIT_EN=0, make no memory access for a misaligned request, and assert rsp_valid=1, rsp_err=1, rsp_rdata=0 in N+1.
REQ-023 SHALL drive mem_wr=mem_rd=0 and mem_op/mem_addr/mem_wdata=0 in any cycle with no issued access.
REQ-024 SHALL ignore req_* inputs while in SPLIT.

Reset
REQ-025 SHALL, while rstn=0, force: state IDLE, byte counter 0, assembly register 0, registered request fields 0, rsp_valid=0, rsp_err=0, rsp_rdata=0, all mem_* outputs 0, req_ready=1 after release.
REQ-026 SHALL, on reset during SPLIT, abandon the access without a response; remaining bytes are not issued.

Verification
REQ-027 SW 0x12345678 @0x100, then LW @0x100 -> mem_wr in N with SW op; LW rsp_valid in accept+1 with rsp_rdata=0x12345678, rsp_err=0.
REQ-028 Word 0x8001_0000 @0x100, LH @0x102 -> single LH access; rsp_rdata=0xFFFF8001; LHU @0x102 -> 0x00008001.
REQ-029 Bytes 0x101..0x104 = 11,22,33,44, LW @0x101 -> LBU @0x101..0x104 in N..N+3; req_ready=0 in N+1..N+3; rsp_valid in N+4 with rsp_rdata=0x44332211.
REQ-030 SH @0x103 with wdata 0x0000BEEF -> SB @0x103 with wdata 0xEF in N, SB @0x104 with wdata 0xBE in N+1; rsp_valid in N+2.
REQ-031 SPLIT_EN=0, LW @0x102 -> no mem_rd; rsp_valid and rsp_err=1 in N+1; rsp_rdata=0.
REQ-032 Reset asserted in N+2 of a misaligned LW -> no rsp_valid, mem_* outputs=0; after release req_ready=1 and an aligned LW completes normally.

Source files
------------

// File: rtl/core_lsu.sv
// Load/store unit. Aligned and illegal accesses respond one cycle after accept.
// Misaligned accesses are either split into byte accesses (SPLIT_EN=1) or rejected.
module core_lsu #(
  parameter bit SPLIT_EN = 1'b1
) (
  input  logic        sclk,
  input  logic        rstn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wr,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mem_wr,
  output logic        mem_rd,
  output logic [2:0]  mem_op,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic {S_IDLE = 1'b0, S_SPLIT = 1'b1} state_t;

  state_t      r_state;
  logic [1:0]  r_cnt;
  logic [31:0] r_asm;
  logic [31:0] r_base;
  logic [31:0] r_wdata;
  logic [2:0]  r_op;
  logic        r_wr;
  logic        r_rsp_vld;
  logic        r_rsp_err;
  logic        r_rsp_ld;
  logic        r_rsp_split;

  logic        w_acc;
  logic        w_legal;
  logic        w_mis;
  logic        w_go;
  logic        w_split;
  logic        w_rej;
  logic [1:0]  w_last;
  logic [7:0]  w_sbyte;
  logic [15:0] w_half;

  // Gating with rstn keeps the memory port quiet while reset is held.
  assign w_acc   = req_valid && (r_state == S_IDLE) && rstn;
  assign w_legal = req_wr ? (req_op inside {3'b000, 3'b001, 3'b010})
                          : (req_op inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
  assign w_mis   = ((req_op[1:0] == 2'b01) && req_addr[0]) ||
                   ((req_op[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
  assign w_go    = w_acc && w_legal && !w_mis;
  assign w_split = w_acc && w_legal && w_mis && SPLIT_EN;
  assign w_rej   = w_acc && !w_go && !w_split;
  assign w_last  = (r_op[1:0] == 2'b01) ? 2'd1 : 2'd3;
  assign w_sbyte = r_wdata[{r_cnt, 3'b000} +: 8];
  assign w_half  = {mem_rdata[7:0], r_asm[7:0]};

  assign req_ready = (r_state == S_IDLE);
  assign rsp_valid = r_rsp_vld;
  assign rsp_err   = r_rsp_err;

  always_comb begin
    mem_wr    = 1'b0;
    mem_rd    = 1'b0;
    mem_op    = 3'b000;
    mem_addr  = 32'd0;
    mem_wdata = 32'd0;
    if (r_state == S_SPLIT) begin
      mem_wr    = r_wr;
      mem_rd    = !r_wr;
      mem_op    = r_wr ? 3'b000 : 3'b100;
      mem_addr  = r_base + {30'd0, r_cnt};
      mem_wdata = {24'd0, w_sbyte};
    end else if (w_go) begin
      mem_wr    = req_wr;
      mem_rd    = !req_wr;
      mem_op    = req_op;
      mem_addr  = req_addr;
      mem_wdata = req_wdata;
    end else if (w_split) begin
      mem_wr    = req_wr;
      mem_rd    = !req_wr;
      mem_op    = req_wr ? 3'b000 : 3'b100;
      mem_addr  = req_addr;
      mem_wdata = {24'd0, req_wdata[7:0]};
    end
  end

  // The final split byte is merged straight from mem_rdata in the response cycle.
  always_comb begin
    rsp_rdata = 32'd0;
    if (r_rsp_vld && !r_rsp_err) begin
      if (r_rsp_split) begin
        if (r_op[1:0] == 2'b01)
          rsp_rdata = r_op[2] ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
        else
          rsp_rdata = {mem_rdata[7:0], r_asm[23:0]};
      end else if (r_rsp_ld) begin
        rsp_rdata = mem_rdata;
      end
    end
  end

  always_ff @(posedge sclk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= S_IDLE;
      r_cnt       <= 2'd0;
      r_asm       <= 32'd0;
      r_base      <= 32'd0;
      r_wdata     <= 32'd0;
      r_op        <= 3'b000;
      r_wr        <= 1'b0;
      r_rsp_vld   <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_ld    <= 1'b0;
      r_rsp_split <= 1'b0;
    end else begin
      r_rsp_vld   <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_ld    <= 1'b0;
      r_rsp_split <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_acc) begin
            r_rsp_vld <= !w_split;
            r_rsp_err <= w_rej;
            r_rsp_ld  <= w_go && !req_wr;
            r_base    <= req_addr;
            r_op      <= req_op;
            r_wr      <= req_wr;
            r_wdata   <= req_wdata;
            r_asm     <= 32'd0;
            if (w_split) begin
              r_cnt   <= 2'd1;
              r_state <= S_SPLIT;
            end
          end
        end
        S_SPLIT: begin
          if (!r_wr)
            r_asm[{r_cnt - 2'd1, 3'b000} +: 8] <= mem_rdata[7:0];
          if (r_cnt == w_last) begin
            r_state     <= S_IDLE;
            r_cnt       <= 2'd0;
            r_rsp_vld   <= 1'b1;
            r_rsp_split <= !r_wr;
          end else begin
            r_cnt <= r_cnt + 2'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_core_lsu.sv
// Bench for core_lsu: byte-array memory behind the DUT, byte-array reference model for requests.
module tb_core_lsu;

  logic sclk = 1'b0;
  logic rstn = 1'b0;
  always #5 sclk = ~sclk;

  logic        req_valid = 1'b0, req_valid0 = 1'b0, req_wr = 1'b0;
  logic [2:0]  req_op = 3'b000;
  logic [31:0] req_addr = 32'd0, req_wdata = 32'd0;

  logic        req_ready, rsp_valid, rsp_err, mem_wr, mem_rd;
  logic [31:0] rsp_rdata, mem_addr, mem_wdata;
  logic [2:0]  mem_op;
  logic [31:0] mem_rdata = 32'd0;

  logic        req_ready0, rsp_valid0, rsp_err0, mem_wr0, mem_rd0;
  logic [31:0] rsp_rdata0, mem_addr0, mem_wdata0;
  logic [2:0]  mem_op0;
  logic [31:0] mem_rdata0 = 32'hC0FFEE11;

  core_lsu #(.SPLIT_EN(1'b1)) u_dut (
    .sclk(sclk), .rstn(rstn), .req_valid(req_valid), .req_ready(req_ready),
    .req_wr(req_wr), .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_wr(mem_wr), .mem_rd(mem_rd), .mem_op(mem_op), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata));

  core_lsu #(.SPLIT_EN(1'b0)) u_dut0 (
    .sclk(sclk), .rstn(rstn), .req_valid(req_valid0), .req_ready(req_ready0),
    .req_wr(req_wr), .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid0), .rsp_rdata(rsp_rdata0), .rsp_err(rsp_err0),
    .mem_wr(mem_wr0), .mem_rd(mem_rd0), .mem_op(mem_op0), .mem_addr(mem_addr0),
    .mem_wdata(mem_wdata0), .mem_rdata(mem_rdata0));

  int n_chk = 0;
  int n_err = 0;

  logic [7:0] mem     [0:4095];
  logic [7:0] ref_mem [0:4095];
  logic       mem_load = 1'b0;

  logic [31:0] iss_addr [0:7];
  logic [31:0] iss_wd   [0:7];
  logic [2:0]  iss_op   [0:7];
  int          iss_cyc  [0:7];

  function automatic logic [31:0] ext(input logic [2:0] op, input logic [31:0] raw);
    case (op)
      3'b000:  return {{24{raw[7]}}, raw[7:0]};
      3'b001:  return {{16{raw[15]}}, raw[15:0]};
      3'b010:  return raw;
      3'b100:  return {24'd0, raw[7:0]};
      3'b101:  return {16'd0, raw[15:0]};
      default: return 32'd0;
    endcase
  endfunction

  // Data memory: lane-selected, extended read data one cycle after mem_rd.
  always @(posedge sclk) begin
    if (mem_load)
      for (int i = 0; i < 4096; i++) mem[i] = ref_mem[i];
    if (mem_wr)
      for (int k = 0; k < (1 << mem_op[1:0]); k++)
        mem[12'(mem_addr + 32'(k))] = mem_wdata[8*k +: 8];
    if (mem_rd)
      mem_rdata <= ext(mem_op, {mem[12'(mem_addr + 32'd3)], mem[12'(mem_addr + 32'd2)],
                                mem[12'(mem_addr + 32'd1)], mem[12'(mem_addr)]});
    else
      mem_rdata <= $urandom;
  end

  function automatic logic [31:0] ref_ld(input logic [2:0] op, input logic [31:0] a);
    return ext(op, {ref_mem[12'(a + 32'd3)], ref_mem[12'(a + 32'd2)],
                    ref_mem[12'(a + 32'd1)], ref_mem[12'(a)]});
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic do_req(input bit wr, input logic [2:0] op, input logic [31:0] addr,
                        input logic [31:0] wdata, input int junk,
                        output logic [31:0] rd, output logic err, output int lat,
                        output int niss, output logic [15:0] rdy);
    @(posedge sclk); #1;
    req_valid = 1'b1; req_wr = wr; req_op = op; req_addr = addr; req_wdata = wdata;
    lat = 0; niss = 0; rdy = 16'd0; rd = 32'd0; err = 1'b0;
    forever begin
      @(negedge sclk);
      rdy[lat] = req_ready;
      if (mem_rd || mem_wr) begin
        if (niss < 8) begin
          iss_addr[niss] = mem_addr; iss_op[niss] = mem_op;
          iss_wd[niss] = mem_wdata; iss_cyc[niss] = lat;
        end
        niss++;
      end
      if (lat > 0 && rsp_valid) begin
        rd = rsp_rdata; err = rsp_err;
        break;
      end
      if (lat >= 10) begin
        lat = -1;
        break;
      end
      @(posedge sclk); #1;
      lat++;
      if (lat <= junk) begin
        req_valid = 1'b1; req_wr = 1'b0; req_op = 3'b010; req_addr = 32'h200;
      end else begin
        req_valid = 1'b0;
      end
    end
    req_valid = 1'b0;
  endtask

  task automatic check_txn(input string nm, input bit wr, input logic [2:0] op,
                           input logic [31:0] addr, input logic [31:0] wdata, input bit junk_en,
                           output logic [31:0] a_rd, output logic a_err, output int a_lat);
    bit lg, ms, e_err;
    int n, e_lat, e_niss, niss;
    logic [31:0] e_rd;
    logic [15:0] rdy;
    n  = 1 << op[1:0];
    lg = wr ? (op <= 3'd2) : (op <= 3'd2 || op == 3'd4 || op == 3'd5);
    ms = (addr % n) != 0;
    if (!lg) begin
      e_err = 1'b1; e_rd = 32'd0; e_lat = 1; e_niss = 0;
    end else begin
      e_err  = 1'b0;
      e_lat  = ms ? n : 1;
      e_niss = e_lat;
      e_rd   = wr ? 32'd0 : ref_ld(op, addr);
    end
    do_req(wr, op, addr, wdata, (junk_en && e_lat > 1) ? e_lat - 1 : 0, a_rd, a_err, a_lat, niss, rdy);
    chk({nm, "_rdata"}, a_rd, e_rd);
    chk({nm, "_err"}, 32'(a_err), 32'(e_err));
    chk({nm, "_latency"}, 32'(a_lat), 32'(e_lat));
    chk({nm, "_issues"}, 32'(niss), 32'(e_niss));
    chk({nm, "_ready"}, 32'(rdy), 32'(1 | (1 << e_lat)));
    for (int k = 0; k < e_niss && k < niss; k++) begin
      chk({nm, "_iss_addr"}, iss_addr[k], addr + 32'(k));
      chk({nm, "_iss_cycle"}, 32'(iss_cyc[k]), 32'(k));
      chk({nm, "_iss_op"}, 32'(iss_op[k]), ms ? (wr ? 32'd0 : 32'd4) : 32'(op));
      if (!ms) chk({nm, "_iss_wdata"}, iss_wd[k], wdata);
      else if (wr) chk({nm, "_iss_wdata"}, iss_wd[k], {24'd0, wdata[8*k +: 8]});
    end
    if (wr && !e_err)
      for (int k = 0; k < n; k++) ref_mem[12'(addr + 32'(k))] = wdata[8*k +: 8];
  endtask

  typedef struct {
    bit          wr;
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          junk;
    bit          err;
    logic [31:0] rd;
    int          lat;
  } vec_t;

  vec_t tab[$];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd, e0, e1;
    logic        err;
    int          lat;
    bit          wr;
    logic [2:0]  op;
    logic [31:0] addr;
    logic [2:0]  lops [5];
    lops = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

    for (int i = 0; i < 4096; i++) ref_mem[i] = 8'($urandom);

    // Reset with a request pending: nothing may leak onto the memory port.
    mem_load = 1'b1;
    req_valid = 1'b1; req_op = 3'b010; req_addr = 32'h100;
    repeat (3) @(posedge sclk);
    @(negedge sclk);
    chk("rst_mem_cmd", {27'd0, mem_wr, mem_rd, mem_op}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_rsp", {30'd0, rsp_valid, rsp_err}, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    req_valid = 1'b0;
    @(posedge sclk); #1;
    rstn = 1'b1; mem_load = 1'b0;
    @(negedge sclk);
    chk("rst_ready", 32'(req_ready), 32'd1);

    tab.push_back('{1'b1, 3'd2, 32'h100, 32'h12345678, 1'b0, 1'b0, 32'h0,        1});
    tab.push_back('{1'b0, 3'd2, 32'h100, 32'h0,        1'b0, 1'b0, 32'h12345678, 1});
    tab.push_back('{1'b1, 3'd2, 32'h100, 32'h80010000, 1'b0, 1'b0, 32'h0,        1});
    tab.push_back('{1'b0, 3'd1, 32'h102, 32'h0,        1'b0, 1'b0, 32'hFFFF8001, 1});
    tab.push_back('{1'b0, 3'd5, 32'h102, 32'h0,        1'b0, 1'b0, 32'h00008001, 1});
    tab.push_back('{1'b1, 3'd0, 32'h101, 32'h11,       1'b0, 1'b0, 32'h0,        1});
    tab.push_back('{1'b1, 3'd0, 32'h102, 32'h22,       1'b0, 1'b0, 32'h0,        1});
    tab.push_back('{1'b1, 3'd0, 32'h103, 32'h33,       1'b0, 1'b0, 32'h0,        1});
    tab.push_back('{1'b1, 3'd0, 32'h104, 32'h44,       1'b0, 1'b0, 32'h0,        1});
    tab.push_back('{1'b0, 3'd2, 32'h101, 32'h0,        1'b1, 1'b0, 32'h44332211, 4});
    tab.push_back('{1'b1, 3'd1, 32'h103, 32'h0000BEEF, 1'b0, 1'b0, 32'h0,        2});
    tab.push_back('{1'b0, 3'd5, 32'h103, 32'h0,        1'b0, 1'b0, 32'h0000BEEF, 2});
    tab.push_back('{1'b0, 3'd1, 32'h103, 32'h0,        1'b1, 1'b0, 32'hFFFFBEEF, 2});
    tab.push_back('{1'b0, 3'd0, 32'h103, 32'h0,        1'b0, 1'b0, 32'hFFFFFFEF, 1});
    tab.push_back('{1'b0, 3'd4, 32'h104, 32'h0,        1'b0, 1'b0, 32'h000000BE, 1});
    tab.push_back('{1'b0, 3'd2, 32'h101, 32'h0,        1'b0, 1'b0, 32'hBEEF2211, 4});
    tab.push_back('{1'b0, 3'd3, 32'h100, 32'h0,        1'b0, 1'b1, 32'h0,        1});
    tab.push_back('{1'b0, 3'd7, 32'h100, 32'h0,        1'b0, 1'b1, 32'h0,        1});
    tab.push_back('{1'b1, 3'd4, 32'h100, 32'hFFFFFFFF, 1'b0, 1'b1, 32'h0,        1});
    tab.push_back('{1'b1, 3'd3, 32'h100, 32'hFFFFFFFF, 1'b0, 1'b1, 32'h0,        1});
    tab.push_back('{1'b0, 3'd2, 32'h100, 32'h0,        1'b0, 1'b0, 32'hEF221100, 1});
    tab.push_back('{1'b1, 3'd2, 32'hFFFFFFFE, 32'hA1B2C3D4, 1'b0, 1'b0, 32'h0,   4});
    tab.push_back('{1'b0, 3'd2, 32'hFFFFFFFE, 32'h0,   1'b1, 1'b0, 32'hA1B2C3D4, 4});

    foreach (tab[i]) begin
      check_txn($sformatf("tab%0d", i), tab[i].wr, tab[i].op, tab[i].addr, tab[i].wdata,
                tab[i].junk, rd, err, lat);
      chk($sformatf("tab%0d_vec_rdata", i), rd, tab[i].rd);
      chk($sformatf("tab%0d_vec_err", i), 32'(err), 32'(tab[i].err));
      chk($sformatf("tab%0d_vec_lat", i), 32'(lat), 32'(tab[i].lat));
    end

    // Back-to-back aligned loads.
    e0 = ref_ld(3'd2, 32'h100);
    e1 = ref_ld(3'd2, 32'h104);
    @(posedge sclk); #1;
    req_valid = 1'b1; req_wr = 1'b0; req_op = 3'd2; req_addr = 32'h100;
    @(negedge sclk);
    chk("b2b_first_addr", mem_rd ? mem_addr : 32'hFFFFFFFF, 32'h100);
    @(posedge sclk); #1;
    req_addr = 32'h104;
    @(negedge sclk);
    chk("b2b_rsp0", rsp_valid ? rsp_rdata : 32'hDEAD0000, e0);
    chk("b2b_second_addr", mem_rd ? mem_addr : 32'hFFFFFFFF, 32'h104);
    @(posedge sclk); #1;
    req_valid = 1'b0;
    @(negedge sclk);
    chk("b2b_rsp1", rsp_valid ? rsp_rdata : 32'hDEAD0000, e1);

    // New accept in the same cycle as a split response.
    e0 = ref_ld(3'd2, 32'h101);
    e1 = ref_ld(3'd2, 32'h108);
    @(posedge sclk); #1;
    req_valid = 1'b1; req_addr = 32'h101;
    repeat (3) begin
      @(posedge sclk); #1;
      req_valid = 1'b0;
    end
    @(posedge sclk); #1;
    req_valid = 1'b1; req_addr = 32'h108;
    @(negedge sclk);
    chk("ovl_split_rsp", rsp_valid ? rsp_rdata : 32'hDEAD0000, e0);
    chk("ovl_ready", 32'(req_ready), 32'd1);
    chk("ovl_new_addr", mem_rd ? mem_addr : 32'hFFFFFFFF, 32'h108);
    @(posedge sclk); #1;
    req_valid = 1'b0;
    @(negedge sclk);
    chk("ovl_new_rsp", rsp_valid ? rsp_rdata : 32'hDEAD0000, e1);

    // SPLIT_EN=0 instance: misaligned rejected, aligned passes through.
    @(posedge sclk); #1;
    req_valid0 = 1'b1; req_wr = 1'b0; req_op = 3'd2; req_addr = 32'h102;
    @(negedge sclk);
    chk("nosplit_no_mem", {30'd0, mem_rd0, mem_wr0}, 32'd0);
    @(posedge sclk); #1;
    req_addr = 32'h100;
    @(negedge sclk);
    chk("nosplit_rsp", {30'd0, rsp_valid0, rsp_err0}, 32'd3);
    chk("nosplit_rdata", rsp_rdata0, 32'd0);
    chk("nosplit_aligned_cmd", mem_rd0 ? mem_addr0 : 32'hFFFFFFFF, 32'h100);
    @(posedge sclk); #1;
    req_valid0 = 1'b0;
    @(negedge sclk);
    chk("nosplit_aligned_rsp", {30'd0, rsp_valid0, rsp_err0}, 32'd2);
    chk("nosplit_aligned_rdata", rsp_rdata0, mem_rdata0);

    // Reset in N+2 of a split load abandons it.
    @(posedge sclk); #1;
    req_valid = 1'b1; req_wr = 1'b0; req_op = 3'd2; req_addr = 32'h101;
    @(posedge sclk); #1;
    req_valid = 1'b0;
    @(posedge sclk); #1;
    rstn = 1'b0;
    @(negedge sclk);
    chk("midrst_mem", {27'd0, mem_wr, mem_rd, mem_op}, 32'd0);
    chk("midrst_mem_addr", mem_addr, 32'd0);
    chk("midrst_rsp", 32'(rsp_valid), 32'd0);
    @(posedge sclk); #1;
    rstn = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge sclk);
      chk("midrst_quiet", {29'd0, mem_rd, mem_wr, rsp_valid}, 32'd0);
      chk("midrst_ready", 32'(req_ready), 32'd1);
      @(posedge sclk); #1;
    end
    check_txn("midrst_lw", 1'b0, 3'd2, 32'h100, 32'h0, 1'b0, rd, err, lat);

    // Random traffic against the reference model.
    for (int t = 0; t < 300; t++) begin
      wr = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) < 8)
        op = wr ? 3'($urandom_range(0, 2)) : lops[$urandom_range(0, 4)];
      else
        op = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 7) == 0) addr = 32'hFFFFFFFC + 32'($urandom_range(0, 3));
      else addr = 32'h100 + 32'($urandom_range(0, 31));
      check_txn($sformatf("rnd%0d", t), wr, op, addr, $urandom, 1'($urandom_range(0, 1)),
                rd, err, lat);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
